// File: rtl/alert_pkg.sv
// alert_pkg -- shared definitions for the alert flag block.
//   state_t      : FSM state encoding (IDLE / HOLD / ALERT)
//   CMD_*        : 2-bit {a,b} command constants
//   cmd_sets     : true for commands that raise q from IDLE
//   cmd_clears   : true for commands that drop q once clearing is permitted
package alert_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    ALERT = 2'd2
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  // SET and TGL both raise the flag from IDLE.
  function automatic logic cmd_sets(input logic [1:0] cmd);
    return (cmd == CMD_SET) || (cmd == CMD_TGL);
  endfunction

  // CLR and TGL both drop the flag from ALERT.
  function automatic logic cmd_clears(input logic [1:0] cmd);
    return (cmd == CMD_CLR) || (cmd == CMD_TGL);
  endfunction

endpackage

// File: rtl/alert_sync.sv
// alert_sync -- N-stage single-bit synchronizer, flops reset to 0.
// Ports:
//   clk : sampling clock
//   rst : asynchronous active-low reset
//   d   : asynchronous input bit
//   q   : synchronized output (last flop of the chain)
module alert_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  // Shift chain: d enters at bit 0, q is taken from bit N-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/alert_module.sv
// alert_module -- JK-style alert flag with a minimum-high hold window.
// Ports:
//   clk   : system clock, all state on rising edge
//   rst   : asynchronous active-low reset
//   a     : set request (J)
//   b     : clear request (K)
//   q     : registered alert flag
//   q_bar : registered complement of q
// Parameters:
//   SYNC_STAGES : synchronizer depth per input (2..4)
//   HOLD_CYCLES : minimum cycles q stays high once raised (0..255)
// Build option:
//   ALERT_INPUT_SYNC_EN : when defined, a and b pass through alert_sync
//   chains before decode; otherwise they are sampled directly.
module alert_module
  import alert_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic q,
  output logic q_bar
);

  // A zero-length hold still needs a 1-bit counter to stay legal.
  localparam int CNT_W = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

  logic         sa;
  logic         sb;
  logic [1:0]   cmd;
  state_t       state;
  logic [CNT_W-1:0] cnt;

`ifdef ALERT_INPUT_SYNC_EN
  alert_sync #(.N(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a),
    .q   (sa)
  );

  alert_sync #(.N(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (b),
    .q   (sb)
  );
`else
  // Inputs are already synchronous to clk in this build.
  assign sa = a;
  assign sb = b;

  logic unused_sync_cfg;
  assign unused_sync_cfg = (SYNC_STAGES != 0);
`endif

  assign cmd = {sa, sb};

  // Alert FSM: q/q_bar are registered together so they can never agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= 1'b0;
      q_bar <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_sets(cmd)) begin
            q     <= 1'b1;
            q_bar <= 1'b0;
            cnt   <= '0;
            state <= (HOLD_CYCLES == 0) ? ALERT : HOLD;
          end
        end
        HOLD: begin
          // Clear/toggle requests are dropped here, not remembered.
          if (cnt == CNT_LAST) begin
            state <= ALERT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ALERT: begin
          // SET while already high leaves q alone and does not re-arm the hold.
          if (cmd_clears(cmd)) begin
            q     <= 1'b0;
            q_bar <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          q     <= 1'b0;
          q_bar <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alert_module.sv
// tb_alert_module -- directed bench for alert_module with a reference
// model and a scoreboard queue per DUT. Two instances share the inputs:
// one with HOLD_CYCLES=4 and one with HOLD_CYCLES=0.
module tb_alert_module;

  localparam int SS = 2;
`ifdef ALERT_INPUT_SYNC_EN
  localparam int LAT = SS + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic q4, qb4, q0, qb0;

  int checks   = 0;
  int failures = 0;

  // Model state: index 0 -> HOLD_CYCLES=4 instance, index 1 -> HOLD_CYCLES=0.
  int   hc[2] = '{4, 0};
  logic mq[2];
  int   hold_left[2];
  logic [1:0] cmd_hist[$];
  logic exp4[$];
  logic exp0[$];

  always #5 clk = ~clk;

  alert_module #(.SYNC_STAGES(SS), .HOLD_CYCLES(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .q     (q4),
    .q_bar (qb4)
  );

  alert_module #(.SYNC_STAGES(SS), .HOLD_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .q     (q0),
    .q_bar (qb0)
  );

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Behavioural reference: after a rise, clears are ignored for hc edges.
  task automatic model_apply(input int d, input logic [1:0] c);
    if (!mq[d]) begin
      if (c[1]) begin
        mq[d]        = 1'b1;
        hold_left[d] = hc[d];
      end
    end else if (hold_left[d] > 0) begin
      hold_left[d] = hold_left[d] - 1;
    end else if (c[0]) begin
      mq[d] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d]        = 1'b0;
      hold_left[d] = 0;
    end
    cmd_hist.delete();
    for (int i = 0; i < LAT - 1; i++) cmd_hist.push_back(2'b00);
    exp4.delete();
    exp0.delete();
  endtask

  // Drive one command for one cycle, advance the model, compare both DUTs.
  task automatic step(input logic na, input logic nb, input string tag);
    logic [1:0] c;
    logic e;
    @(negedge clk);
    a = na;
    b = nb;
    @(posedge clk);
    #1;
    cmd_hist.push_back({na, nb});
    c = cmd_hist.pop_front();
    model_apply(0, c);
    model_apply(1, c);
    exp4.push_back(mq[0]);
    exp0.push_back(mq[1]);
    e = exp4.pop_front();
    check({tag, "/q_h4"}, q4, e);
    check({tag, "/qbar_h4"}, qb4, ~e);
    e = exp0.pop_front();
    check({tag, "/q_h0"}, q0, e);
    check({tag, "/qbar_h0"}, qb0, ~e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/q_h4"}, q4, 1'b0);
    check({tag, "/qbar_h4"}, qb4, 1'b1);
    check({tag, "/q_h0"}, q0, 1'b0);
    check({tag, "/qbar_h0"}, qb0, 1'b1);
  endtask

  // Hard time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] pat;
    rst = 1'b0;
    model_reset();

    // Reset held while every command pattern is presented.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat = 2'(i);
      a = pat[1];
      b = pat[0];
      @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
    end
    a = 1'b0;
    b = 1'b0;
    rst = 1'b1;

    // Idle quiet, then set and try to clear inside the hold window.
    step(1'b0, 1'b0, "idle");
    step(1'b1, 1'b0, "set");
    for (int i = 0; i < LAT; i++) step(1'b1, 1'b0, "set_lat");
    step(1'b0, 1'b1, "clr_in_hold");
    step(1'b0, 1'b1, "clr_in_hold");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "wait_hold");
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, "clr_after_hold");

    // Continuous toggle: HOLD_CYCLES=0 alternates, HOLD_CYCLES=4 is 5 high / 1 low.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, "toggle");
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, "clr");

    // SET while in ALERT must not re-arm the hold; a following clear acts at once.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "set_to_alert");
    step(1'b1, 1'b0, "set_in_alert");
    for (int i = 0; i < LAT + 1; i++) step(1'b0, 1'b1, "clr_alert");

    // Back to ALERT, then reset between edges.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "set_again");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    a = 1'b0;
    b = 1'b0;
    model_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "after_reset");

    // Fresh set after reset release.
    for (int i = 0; i < LAT + 2; i++) step(1'b1, 1'b0, "set_post_reset");
    step(1'b0, 1'b0, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
